// File: rtl/timer_multi_ch.sv
// Multi-channel interval timer: one shared prescaler drives NUM_CH independent
// periodic/one-shot counters with expiry pulses, sticky flags and a combined irq.
module timer_multi_ch #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PRESCALE_W-1:0]   prescale_div,
    input  logic [NUM_CH-1:0]       ch_ena,
    input  logic [NUM_CH-1:0]       ch_clr,
    input  logic [NUM_CH-1:0]       ch_mode,
    input  logic [NUM_CH*CNT_W-1:0] ch_period,
    input  logic [NUM_CH-1:0]       ch_irq_en,
    input  logic [NUM_CH-1:0]       ch_flag_clr,
    output logic [NUM_CH-1:0]       ch_tick,
    output logic [NUM_CH-1:0]       ch_busy,
    output logic [NUM_CH-1:0]       ch_flag,
    output logic [NUM_CH*CNT_W-1:0] ch_cnt,
    output logic                    irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ch_state_t;

    logic [PRESCALE_W-1:0] pre_cnt;
    logic                  tick;

    // Shared prescaler; '>=' makes a lowered divisor wrap on the next clock.
    assign tick = (pre_cnt >= prescale_div);

    always_ff @(posedge clk) begin : prescaler
        if (rst) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRESCALE_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_state_t        state;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] period_q;
        logic [CNT_W-1:0] period_in;
        logic             tick_q;
        logic             busy_q;

        assign period_in = ch_period[i*CNT_W +: CNT_W];

        // Per-channel FSM; clear beats everything, disable beats expiry.
        always_ff @(posedge clk) begin : fsm
            if (rst) begin
                state    <= ST_IDLE;
                cnt      <= '0;
                period_q <= '0;
                tick_q   <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                tick_q <= 1'b0;
                if (ch_clr[i]) begin
                    state  <= ST_IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (ch_ena[i]) begin
                                state    <= ST_RUN;
                                period_q <= period_in;
                                cnt      <= '0;
                                busy_q   <= 1'b1;
                            end
                        end
                        ST_RUN: begin
                            if (!ch_ena[i]) begin
                                state  <= ST_IDLE;
                                cnt    <= '0;
                                busy_q <= 1'b0;
                            end else if (tick) begin
                                if (cnt == period_q) begin
                                    tick_q <= 1'b1;
                                    cnt    <= '0;
                                    if (ch_mode[i]) begin
                                        state  <= ST_DONE;
                                        busy_q <= 1'b0;
                                    end else begin
                                        period_q <= period_in;
                                    end
                                end else begin
                                    cnt <= cnt + CNT_W'(1);
                                end
                            end
                        end
                        ST_DONE: begin
                            if (!ch_ena[i]) begin
                                state <= ST_IDLE;
                            end
                        end
                        default: begin
                            state  <= ST_IDLE;
                            cnt    <= '0;
                            busy_q <= 1'b0;
                        end
                    endcase
                end
            end
        end

        assign ch_tick[i]                = tick_q;
        assign ch_busy[i]                = busy_q;
        assign ch_cnt[i*CNT_W +: CNT_W] = cnt;
    end

    // Sticky flags (set wins over clear) and the masked interrupt.
    always_ff @(posedge clk) begin : flags
        if (rst) begin
            ch_flag <= '0;
            irq     <= 1'b0;
        end else begin
            ch_flag <= (ch_flag & ~ch_flag_clr) | ch_tick;
            irq     <= |(ch_flag & ch_irq_en);
        end
    end

endmodule

// File: tb/tb_timer_multi_ch.sv
// Self-checking bench for timer_multi_ch: directed scenarios with fixed expected
// cycles plus randomized stimulus against a ticks-remaining reference model.
module tb_timer_multi_ch;
    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned PRESCALE_W = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [PRESCALE_W-1:0]   prescale_div;
    logic [NUM_CH-1:0]       ch_ena, ch_clr, ch_mode, ch_irq_en, ch_flag_clr;
    logic [NUM_CH*CNT_W-1:0] ch_period;
    logic [NUM_CH-1:0]       ch_tick, ch_busy, ch_flag;
    logic [NUM_CH*CNT_W-1:0] ch_cnt;
    logic                    irq;

    int passes = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: a channel is running/spent/idle, and counts prescaler
    // ticks still owed before it expires; the visible count is period - left.
    int                m_phase;
    bit [NUM_CH-1:0]   m_run, m_spent;
    int                m_left [NUM_CH];
    int                m_per  [NUM_CH];
    logic [NUM_CH-1:0] m_tick, m_flag;
    logic              m_irq;

    timer_multi_ch #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE_W(PRESCALE_W)) dut (
        .clk(clk), .rst(rst), .prescale_div(prescale_div), .ch_ena(ch_ena),
        .ch_clr(ch_clr), .ch_mode(ch_mode), .ch_period(ch_period),
        .ch_irq_en(ch_irq_en), .ch_flag_clr(ch_flag_clr), .ch_tick(ch_tick),
        .ch_busy(ch_busy), .ch_flag(ch_flag), .ch_cnt(ch_cnt), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        bit                pt;
        int                per_in;
        logic [NUM_CH-1:0] expired;
        if (rst) begin
            m_phase = 0; m_run = '0; m_spent = '0;
            m_tick = '0; m_flag = '0; m_irq = 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin m_left[i] = 0; m_per[i] = 0; end
            return;
        end
        pt      = (m_phase >= int'(prescale_div));
        m_phase = pt ? 0 : m_phase + 1;
        m_irq   = |(m_flag & ch_irq_en);
        m_flag  = (m_flag & ~ch_flag_clr) | m_tick;
        expired = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            per_in = int'(ch_period[i*CNT_W +: CNT_W]);
            if (ch_clr[i] || (!ch_ena[i] && (m_run[i] || m_spent[i]))) begin
                m_run[i] = 1'b0; m_spent[i] = 1'b0;
            end else if (!m_run[i] && !m_spent[i] && ch_ena[i]) begin
                m_run[i] = 1'b1; m_per[i] = per_in; m_left[i] = per_in;
            end else if (m_run[i] && pt) begin
                if (m_left[i] == 0) begin
                    expired[i] = 1'b1;
                    if (ch_mode[i]) begin
                        m_run[i] = 1'b0; m_spent[i] = 1'b1;
                    end else begin
                        m_per[i] = per_in; m_left[i] = per_in;
                    end
                end else begin
                    m_left[i] = m_left[i] - 1;
                end
            end
        end
        m_tick = expired;
    endtask

    function automatic logic [NUM_CH*CNT_W-1:0] model_cnt();
        logic [NUM_CH*CNT_W-1:0] v = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (m_run[i]) v[i*CNT_W +: CNT_W] = CNT_W'(m_per[i] - m_left[i]);
        return v;
    endfunction

    task automatic clk_step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; prescale_div = '0; ch_ena = '0; ch_clr = '0; ch_mode = '0;
        ch_period = '0; ch_irq_en = '0; ch_flag_clr = '0;
        clk_step(); clk_step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; prescale_div = PRESCALE_W'(5); ch_ena = '1; ch_clr = '1; ch_mode = '1;
        ch_period = {NUM_CH{16'h0003}}; ch_irq_en = '1; ch_flag_clr = '1;
        for (int k = 0; k < 3; k++) begin
            clk_step();
            checks++;
            if (ch_tick !== 4'h0 || ch_busy !== 4'h0 || ch_flag !== 4'h0 || ch_cnt !== 64'h0 || irq !== 1'b0)
                $display("FAIL reset_hold[%0d]: tick=%h busy=%h flag=%h cnt=%h irq=%b, want all 0",
                         k, ch_tick, ch_busy, ch_flag, ch_cnt, irq);
            else passes++;
        end
        rst = 1'b0; ch_ena = '0; ch_clr = '0; ch_mode = '0; ch_flag_clr = '0; prescale_div = '0;
        clk_step(); clk_step();
        checks++;
        if (ch_busy !== 4'h0 || ch_cnt !== 64'h0)
            $display("FAIL reset_idle: busy=%h cnt=%h, want 0/0", ch_busy, ch_cnt);
        else passes++;
        ch_ena = 4'b0001;
        clk_step();
        checks++;
        if (ch_busy !== 4'b0001 || ch_cnt[15:0] !== 16'd0)
            $display("FAIL reset_first_ena: busy=%h cnt0=%0d, want 1/0", ch_busy, ch_cnt[15:0]);
        else passes++;
        clk_step();
        checks++;
        if (ch_cnt[15:0] !== 16'd1) $display("FAIL reset_count: cnt0=%0d want 1", ch_cnt[15:0]);
        else passes++;
        ch_ena = '0;
        clk_step();
    endtask

    task automatic test_periodic();
        do_reset();
        ch_period[15:0] = 16'd3; ch_irq_en = 4'b0001; ch_ena = 4'b0001;
        for (int c = 1; c <= 14; c++) begin
            clk_step();
            checks++;
            if (ch_tick[0] !== (c == 5 || c == 9 || c == 13))
                $display("FAIL periodic_tick cyc%0d: got %b want %b", c, ch_tick[0], (c == 5 || c == 9 || c == 13));
            else passes++;
            if (c == 1) begin
                checks++;
                if (ch_busy[0] !== 1'b1) $display("FAIL periodic_busy: got %b want 1", ch_busy[0]);
                else passes++;
            end
            if (c == 5 || c == 6) begin
                checks++;
                if (ch_flag[0] !== (c == 6)) $display("FAIL periodic_flag cyc%0d: got %b want %b", c, ch_flag[0], c == 6);
                else passes++;
            end
            if (c == 7) begin
                checks++;
                if (irq !== 1'b1) $display("FAIL periodic_irq: got %b want 1", irq);
                else passes++;
            end
        end
    endtask

    task automatic test_one_shot();
        int n_ticks = 0;
        int first   = -1;
        do_reset();
        prescale_div = PRESCALE_W'(2); ch_period[15:0] = 16'd1; ch_mode = 4'b0001; ch_ena = 4'b0001;
        for (int c = 1; c <= 20; c++) begin
            clk_step();
            if (ch_tick[0] === 1'b1) begin n_ticks++; if (first < 0) first = c; end
            checks++;
            if (ch_tick !== m_tick) $display("FAIL oneshot_model cyc%0d: got %h want %h", c, ch_tick, m_tick);
            else passes++;
        end
        checks++;
        if (n_ticks != 1 || first < 5 || first > 7)
            $display("FAIL oneshot_count: got %0d ticks first at %0d, want 1 tick in cycles 5..7", n_ticks, first);
        else passes++;
        checks++;
        if (ch_busy[0] !== 1'b0 || ch_cnt[15:0] !== 16'd0)
            $display("FAIL oneshot_done: busy=%b cnt=%0d want 0/0", ch_busy[0], ch_cnt[15:0]);
        else passes++;
        ch_ena = '0; clk_step();
        ch_ena = 4'b0001; clk_step();
        checks++;
        if (ch_busy[0] !== 1'b1) $display("FAIL oneshot_rearm: busy=%b want 1", ch_busy[0]);
        else passes++;
        n_ticks = 0;
        for (int c = 0; c < 12; c++) begin
            clk_step();
            if (ch_tick[0] === 1'b1) n_ticks++;
        end
        checks++;
        if (n_ticks != 1) $display("FAIL oneshot_rearm_ticks: got %0d want 1", n_ticks);
        else passes++;
    endtask

    task automatic test_clear_abort();
        int bad = 0;
        do_reset();
        ch_period[31:16] = 16'd3; ch_ena = 4'b0010;
        while (cyc < 4) clk_step();
        checks++;
        if (ch_cnt[31:16] !== 16'd3) $display("FAIL clear_pre: cnt1=%0d want 3", ch_cnt[31:16]);
        else passes++;
        ch_clr = 4'b0010;
        clk_step();
        ch_clr = '0;
        checks++;
        if (ch_tick[1] !== 1'b0 || ch_cnt[31:16] !== 16'd0 || ch_busy[1] !== 1'b0)
            $display("FAIL clear_expiry: tick=%b cnt=%0d busy=%b want 0/0/0", ch_tick[1], ch_cnt[31:16], ch_busy[1]);
        else passes++;
        while (cyc < 8) clk_step();
        checks++;
        if (ch_busy[1] !== 1'b1 || ch_cnt[31:16] !== 16'd2)
            $display("FAIL abort_pre: busy=%b cnt=%0d want 1/2", ch_busy[1], ch_cnt[31:16]);
        else passes++;
        ch_ena = '0;
        for (int c = 0; c < 8; c++) begin
            clk_step();
            if (ch_tick[1] !== 1'b0 || ch_busy[1] !== 1'b0 || ch_cnt[31:16] !== 16'd0 || ch_flag[1] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL abort_idle: %0d bad cycles, want 0", bad);
        else passes++;
    endtask

    task automatic test_flag_irq();
        do_reset();
        ch_period[47:32] = 16'd2; ch_ena = 4'b0100;
        while (cyc < 6) clk_step();
        checks++;
        if (ch_flag[2] !== 1'b1 || irq !== 1'b0)
            $display("FAIL flag_masked: flag=%b irq=%b want 1/0", ch_flag[2], irq);
        else passes++;
        ch_irq_en = 4'b0100;
        clk_step();
        checks++;
        if (irq !== 1'b1 || ch_tick[2] !== 1'b1)
            $display("FAIL irq_unmask: irq=%b tick=%b want 1/1", irq, ch_tick[2]);
        else passes++;
        ch_flag_clr = 4'b0100;
        clk_step();
        checks++;
        if (ch_flag[2] !== 1'b1) $display("FAIL flag_set_wins: flag=%b want 1", ch_flag[2]);
        else passes++;
        clk_step();
        ch_flag_clr = '0;
        checks++;
        if (ch_flag[2] !== 1'b0) $display("FAIL flag_clear: flag=%b want 0", ch_flag[2]);
        else passes++;
        clk_step();
        checks++;
        if (irq !== 1'b0) $display("FAIL irq_clear: irq=%b want 0", irq);
        else passes++;
    endtask

    task automatic test_multi_reload();
        logic [NUM_CH-1:0] want;
        do_reset();
        ch_period = {16'd3, 16'd2, 16'd1, 16'd0}; ch_ena = '1;
        for (int c = 1; c <= 26; c++) begin
            clk_step();
            for (int i = 0; i < NUM_CH; i++) want[i] = (c > 1) && ((c - 1) % (i + 1) == 0);
            checks++;
            if (ch_tick !== want) $display("FAIL multi_tick cyc%0d: got %h want %h", c, ch_tick, want);
            else passes++;
        end
        ch_period[63:48] = 16'd1;
        for (int c = 27; c <= 42; c++) begin
            clk_step();
            checks++;
            if (ch_tick[3] !== (c >= 29 && (c - 29) % 2 == 0))
                $display("FAIL reload_tick cyc%0d: got %b want %b", c, ch_tick[3], (c >= 29 && (c - 29) % 2 == 0));
            else passes++;
        end
    endtask

    task automatic test_random();
        do_reset();
        ch_irq_en = NUM_CH'($urandom);
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 39) == 0) prescale_div = PRESCALE_W'($urandom_range(0, 3));
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 11) == 0) ch_ena[i] = ~ch_ena[i];
                ch_clr[i]      = ($urandom_range(0, 29) == 0);
                ch_flag_clr[i] = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 19) == 0) ch_mode[i] = ~ch_mode[i];
                if ($urandom_range(0, 15) == 0) ch_irq_en[i] = ~ch_irq_en[i];
                if ($urandom_range(0, 7) == 0) ch_period[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 6));
            end
            clk_step();
            checks++;
            if (ch_tick !== m_tick) $display("FAIL rand_tick n%0d: got %h want %h", n, ch_tick, m_tick);
            else passes++;
            checks++;
            if (ch_busy !== m_run) $display("FAIL rand_busy n%0d: got %h want %h", n, ch_busy, m_run);
            else passes++;
            checks++;
            if (ch_flag !== m_flag) $display("FAIL rand_flag n%0d: got %h want %h", n, ch_flag, m_flag);
            else passes++;
            checks++;
            if (ch_cnt !== model_cnt()) $display("FAIL rand_cnt n%0d: got %h want %h", n, ch_cnt, model_cnt());
            else passes++;
            checks++;
            if (irq !== m_irq) $display("FAIL rand_irq n%0d: got %b want %b", n, irq, m_irq);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_one_shot();
        test_clear_abort();
        test_flag_irq();
        test_multi_reload();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
